fakeram130_sp_init: RTL and testbench

- Parametrised behavioural single-port SRAM model for the sky130hd fakeram macro family.
- Generalises the fixed 2x576 macro in width, depth, read latency and read-during-write mode.
- Adds a self-clearing initialisation sequencer, a busy flag and a read-valid strobe, so cores such as serv can be simulated and synthesised without a hard macro.

---
 rtl/fakeram130_sp_init.sv | 120 ++++++++++++
 tb/tb_fakeram130_sp_init.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fakeram130_sp_init.sv
// Behavioural single-port SRAM with a self-clearing init sequence, busy flag
// and read-valid strobe; drop-in stand-in for the sky130 fakeram macros.
module fakeram130_sp_init #(
  parameter int unsigned     BITS          = 2,
  parameter int unsigned     WORD_DEPTH    = 576,
  parameter int unsigned     ADDR_WIDTH    = 10,
  parameter int unsigned     RD_LATENCY    = 1,
  parameter logic [BITS-1:0] INIT_VALUE    = '0,
  parameter bit              WRITE_THROUGH = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  ce_in,
  input  logic                  we_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [BITS-1:0]       wd_in,
  input  logic [BITS-1:0]       w_mask_in,
  output logic [BITS-1:0]       rd_out,
  output logic                  rd_valid_out,
  output logic                  busy_out
);

  localparam int unsigned           IDX_W     = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  busy_d;

  logic [BITS-1:0]       mem [WORD_DEPTH];
  logic                  in_range;
  logic [BITS-1:0]       rd_word;
  logic [BITS-1:0]       merged;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [BITS-1:0]       mem_wdata;
  logic                  acc_valid;
  logic [BITS-1:0]       acc_data;

  logic                  pipe_valid_q;
  logic [BITS-1:0]       pipe_data_q;

  // Out-of-range addresses read as zero and never touch the array
  assign in_range = 32'(addr_in) < WORD_DEPTH;
  assign rd_word  = in_range ? mem[IDX_W'(addr_in)] : '0;
  assign merged   = (rd_word & ~w_mask_in) | (wd_in & w_mask_in);

  // Next-state, array write port and access result
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_out;
    mem_we    = 1'b0;
    mem_waddr = addr_in;
    mem_wdata = merged;
    acc_valid = 1'b0;
    acc_data  = '0;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = INIT_VALUE;
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
        end
      end
      ST_READY: begin
        if (ce_in) begin
          if (we_in) begin
            mem_we    = in_range;
            acc_valid = WRITE_THROUGH;
            acc_data  = in_range ? merged : '0;
          end else begin
            acc_valid = 1'b1;
            acc_data  = rd_word;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[IDX_W'(mem_waddr)] <= mem_wdata;
    end
  end

  // Control state and read pipeline; RD_LATENCY=2 inserts one stage
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= '0;
      busy_out     <= 1'b1;
      pipe_valid_q <= 1'b0;
      pipe_data_q  <= '0;
      rd_valid_out <= 1'b0;
      rd_out       <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      busy_out     <= busy_d;
      pipe_valid_q <= acc_valid;
      pipe_data_q  <= acc_data;
      if (RD_LATENCY == 2) begin
        rd_valid_out <= pipe_valid_q;
        if (pipe_valid_q) rd_out <= pipe_data_q;
      end else begin
        rd_valid_out <= acc_valid;
        if (acc_valid) rd_out <= acc_data;
      end
    end
  end

endmodule

// File: tb/tb_fakeram130_sp_init.sv
// Scoreboard bench: three parameterisations share one stimulus stream and are
// checked against an array-based reference model.
module tb_fakeram130_sp_init;

  localparam int N = 3;
  localparam int BITS_T  [N] = '{2, 8, 2};
  localparam int DEPTH_T [N] = '{576, 16, 576};
  localparam int AW_T    [N] = '{10, 5, 10};
  localparam int LAT_T   [N] = '{1, 2, 2};
  localparam int INIT_T  [N] = '{0, 'h5A, 1};
  localparam int WT_T    [N] = '{0, 1, 1};

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;

  exp_t sb [N][$];

  logic       clk = 1'b0;
  logic       rst, ce, we;
  logic [9:0] addr;
  logic [7:0] wd, mask;
  logic [1:0] rd_a, rd_c;
  logic [7:0] rd_b;
  logic [N-1:0] vld, bsy;
  logic [7:0] rd_o [N];

  always #5 clk = ~clk;

  assign rd_o[0] = {6'b0, rd_a};
  assign rd_o[1] = rd_b;
  assign rd_o[2] = {6'b0, rd_c};

  fakeram130_sp_init #(.BITS(2), .WORD_DEPTH(576), .ADDR_WIDTH(10), .RD_LATENCY(1),
                       .INIT_VALUE(2'b00), .WRITE_THROUGH(1'b0)) u_a (
    .clk(clk), .rst_in(rst), .ce_in(ce), .we_in(we), .addr_in(addr),
    .wd_in(wd[1:0]), .w_mask_in(mask[1:0]), .rd_out(rd_a),
    .rd_valid_out(vld[0]), .busy_out(bsy[0]));

  fakeram130_sp_init #(.BITS(8), .WORD_DEPTH(16), .ADDR_WIDTH(5), .RD_LATENCY(2),
                       .INIT_VALUE(8'h5A), .WRITE_THROUGH(1'b1)) u_b (
    .clk(clk), .rst_in(rst), .ce_in(ce), .we_in(we), .addr_in(addr[4:0]),
    .wd_in(wd), .w_mask_in(mask), .rd_out(rd_b),
    .rd_valid_out(vld[1]), .busy_out(bsy[1]));

  fakeram130_sp_init #(.BITS(2), .WORD_DEPTH(576), .ADDR_WIDTH(10), .RD_LATENCY(2),
                       .INIT_VALUE(2'b01), .WRITE_THROUGH(1'b1)) u_c (
    .clk(clk), .rst_in(rst), .ce_in(ce), .we_in(we), .addr_in(addr),
    .wd_in(wd[1:0]), .w_mask_in(mask[1:0]), .rd_out(rd_c),
    .rd_valid_out(vld[2]), .busy_out(bsy[2]));

  // Reference model state, owned by the stimulus process
  logic [7:0] mm [N][576];
  int         busy_cnt [N];
  bit         exp_busy [N];
  int         cyc      = 0;
  bit         started  = 1'b0;
  bit         rst_edge = 1'b0;

  // Monitor state
  logic [7:0] hold [N];
  int         checks = 0;
  int         passes = 0;

  task automatic access(input int d);
    int         a;
    logic [7:0] wm, w, m, res;
    bit         inr;
    exp_t       e;
    a   = int'(addr) % (1 << AW_T[d]);
    wm  = 8'((1 << BITS_T[d]) - 1);
    w   = wd & wm;
    m   = mask & wm;
    inr = a < DEPTH_T[d];
    e.due = cyc + LAT_T[d] - 1;
    if (we) begin
      res = inr ? ((mm[d][a] & ~m) | (w & m)) : 8'h00;
      if (inr) mm[d][a] = res;
      if (WT_T[d] != 0) begin
        e.data = res;
        sb[d].push_back(e);
      end
    end else begin
      e.data = inr ? mm[d][a] : 8'h00;
      sb[d].push_back(e);
    end
  endtask

  // Advance the model by one rising edge using the inputs the DUTs just sampled
  task automatic model_edge();
    cyc++;
    started  = 1'b1;
    rst_edge = rst;
    for (int d = 0; d < N; d++) begin
      if (rst) begin
        busy_cnt[d] = DEPTH_T[d];
        sb[d].delete();
        for (int i = 0; i < DEPTH_T[d]; i++) mm[d][i] = 8'(INIT_T[d]);
      end else if (busy_cnt[d] > 0) begin
        busy_cnt[d]--;
      end else if (ce) begin
        access(d);
      end
      exp_busy[d] = busy_cnt[d] > 0;
    end
  endtask

  task automatic cycle(input bit c, input bit w, input logic [9:0] a,
                       input logic [7:0] dta, input logic [7:0] m);
    ce = c; we = w; addr = a; wd = dta; mask = m;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input bit ok, input string name, input int d,
                     input int act, input int req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, d, cyc, act, req);
  endtask

  // Monitor: pops the scoreboard whenever a DUT strobes rd_valid_out
  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < N; d++) begin
        exp_t e;
        if (rst_edge) hold[d] = 8'h00;
        chk(bsy[d] == exp_busy[d], "busy", d, 32'(bsy[d]), 32'(exp_busy[d]));
        if (vld[d]) begin
          if (sb[d].size() == 0) begin
            chk(1'b0, "unexpected_valid", d, 32'(rd_o[d]), 0);
          end else begin
            e = sb[d].pop_front();
            chk(e.due == cyc, "latency", d, cyc, e.due);
            chk(rd_o[d] == e.data, "rd_data", d, 32'(rd_o[d]), 32'(e.data));
            hold[d] = e.data;
          end
        end else begin
          if (sb[d].size() > 0 && sb[d][0].due <= cyc) begin
            e = sb[d].pop_front();
            chk(1'b0, "missing_valid", d, 0, 32'(e.data));
          end
          chk(rd_o[d] == hold[d], "rd_hold", d, 32'(rd_o[d]), 32'(hold[d]));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; wd = '0; mask = '0;
    repeat (2) cycle(1'b0, 1'b0, 10'd0, 8'h00, 8'h00);
    rst = 1'b0;
    // Reads issued throughout the clear must be ignored
    repeat (600) cycle(1'b1, 1'b0, 10'($urandom_range(0, 575)), 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 10'd575, 8'h00, 8'h00);
    // Masked writes then readback
    cycle(1'b1, 1'b1, 10'd5, 8'hFF, 8'hFF);
    cycle(1'b1, 1'b1, 10'd5, 8'h00, 8'h01);
    cycle(1'b1, 1'b0, 10'd5, 8'h00, 8'h00);
    // Back-to-back reads
    cycle(1'b1, 1'b1, 10'd3, 8'hA5, 8'hFF);
    cycle(1'b1, 1'b1, 10'd4, 8'h3C, 8'hFF);
    cycle(1'b1, 1'b0, 10'd3, 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 10'd4, 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 10'd3, 8'h00, 8'h00);
    // Out of range write/read, then the aliased in-range address
    cycle(1'b1, 1'b1, 10'd600, 8'hFF, 8'hFF);
    cycle(1'b1, 1'b0, 10'd600, 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 10'd88, 8'h00, 8'h00);
    // Partial write, write-through visible only where enabled
    cycle(1'b1, 1'b1, 10'd7, 8'h02, 8'h02);
    repeat (3) cycle(1'b0, 1'b0, 10'd0, 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 10'd7, 8'h00, 8'h00);
    // Randomised traffic, mostly on a small hot address range
    repeat (400) begin
      logic [9:0] a;
      a = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 15));
      cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, 8'($urandom), 8'($urandom));
    end
    // Reset one edge after a read is accepted
    cycle(1'b1, 1'b1, 10'd9, 8'hFF, 8'hFF);
    cycle(1'b1, 1'b0, 10'd9, 8'h00, 8'h00);
    rst = 1'b1;
    cycle(1'b1, 1'b0, 10'd9, 8'h00, 8'h00);
    rst = 1'b0;
    repeat (580) cycle(1'b1, 1'b0, 10'd9, 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 10'd5, 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 10'd3, 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 10'd4, 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 10'd7, 8'h00, 8'h00);
    repeat (4) cycle(1'b0, 1'b0, 10'd0, 8'h00, 8'h00);
    for (int d = 0; d < N; d++) begin
      chk(sb[d].size() == 0, "drain", d, sb[d].size(), 0);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
